spi_cmd_ctrl: RTL and testbench

Command-layer controller behind the byte-level SPI slave, running entirely on sys_clk. It synchronises the slave's chip-select and byte-ready signals and decodes a command byte {rw, addr}. It then sequences burst writes into, or burst reads out of, an external register bank with address auto-increment. For reads, it drives the slave's parallel load port (tx_byte / tx_load) so each next byte is queued before the master clocks it out.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/sync_edge.sv | 38 +++
 rtl/spi_cmd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg: shared constants and FSM state encoding for the SPI command layer.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam logic [BYTE_W-1:0] STATUS_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WR_DATA  = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_LOAD  = 3'd4,
    ST_RD_WAIT  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge: STAGES-deep synchroniser with one-cycle rise/fall pulse outputs.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edge pulses come from two flops only, so they are glitch-free
  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl: SPI command decoder sequencing burst register reads/writes.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_cmd_ctrl
  import spi_pkg::*;
#(
  parameter int                ADDR_W      = 7,
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              byte_rdy,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_we,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);

  logic cs_lvl, cs_rise, cs_fall;
  logic rdy_lvl, byte_strobe, rdy_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d_i     (cs),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .d_i     (byte_rdy),
    .level_o (rdy_lvl),
    .rise_o  (byte_strobe),
    .fall_o  (rdy_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, cs_lvl, rdy_lvl, rdy_fall, byte_in};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              overrun_q, overrun_d;
  logic              we_d, re_d, load_d, ovr_set;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      tx_byte_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_byte_q <= tx_byte_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_byte_d = tx_byte_q;
    overrun_d = overrun_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    load_d    = 1'b0;
    ovr_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          tx_byte_d = STATUS_BYTE;
          load_d    = 1'b1;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        if (byte_strobe) begin
          addr_d  = byte_in[ADDR_W-1:0];
          state_d = byte_in[CMD_RW_BIT] ? ST_RD_FETCH : ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (byte_strobe) begin
          we_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_RD_FETCH: begin
        re_d    = 1'b1;
        state_d = ST_RD_LOAD;
        ovr_set = byte_strobe;
      end
      ST_RD_LOAD: begin
        tx_byte_d = reg_rdata;
        load_d    = 1'b1;
        addr_d    = addr_q + ADDR_W'(1);
        state_d   = ST_RD_WAIT;
        ovr_set   = byte_strobe;
      end
      ST_RD_WAIT: begin
        if (byte_strobe) begin
          state_d = ST_RD_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing chip select cancels everything decided this cycle
    if (cs_fall && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      addr_d    = addr_q;
      tx_byte_d = tx_byte_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      load_d    = 1'b0;
      ovr_set   = 1'b0;
    end

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (ovr_set) begin
      overrun_d = 1'b1;
    end

    if (rst) begin
      tx_byte_d = '0;
      we_d      = 1'b0;
      re_d      = 1'b0;
      load_d    = 1'b0;
    end
  end

  // tx_byte shows the value being loaded so the slave latches it with tx_load
  assign tx_byte   = tx_byte_d;
  assign tx_load   = load_d;
  assign reg_addr  = addr_q;
  assign reg_we    = we_d;
  assign reg_wdata = we_d ? byte_in : '0;
  assign reg_re    = re_d;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ctrl: randomized self-checking bench against a transaction model.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_spi_cmd_ctrl;

  localparam int ADDR_W      = 7;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam logic [7:0] STATUS = 8'hA5;

  logic              sys_clk = 1'b0;
  logic              rst, cs, byte_rdy, clr_overrun;
  logic [7:0]        byte_in;
  logic [7:0]        reg_rdata;
  logic [7:0]        tx_byte, reg_wdata;
  logic              tx_load, reg_we, reg_re, busy, overrun;
  logic [ADDR_W-1:0] reg_addr;

  spi_cmd_ctrl #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC_STAGES),
    .STATUS_BYTE (STATUS)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .cs          (cs),
    .byte_rdy    (byte_rdy),
    .byte_in     (byte_in),
    .tx_byte     (tx_byte),
    .tx_load     (tx_load),
    .reg_addr    (reg_addr),
    .reg_we      (reg_we),
    .reg_wdata   (reg_wdata),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register bank emulation
  logic [7:0] init_vals [DEPTH];
  logic [7:0] bank      [DEPTH];
  logic       bank_init;

  always @(posedge sys_clk) begin
    if (bank_init) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= init_vals[i];
      reg_rdata <= 8'h00;
    end else begin
      if (reg_re) reg_rdata <= bank[reg_addr];
      if (reg_we) bank[reg_addr] <= reg_wdata;
    end
  end

  // Observed activity
  logic [14:0] got_we [$];
  logic [6:0]  got_re [$];
  logic [7:0]  got_tx [$];

  always @(negedge sys_clk) begin
    if (reg_we)  got_we.push_back({reg_addr, reg_wdata});
    if (reg_re)  got_re.push_back(reg_addr);
    if (tx_load) got_tx.push_back(tx_byte);
  end

  // Reference model state
  logic [7:0]  ref_mem [DEPTH];
  logic        exp_ovr;
  logic [14:0] exp_we [$];
  logic [6:0]  exp_re [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  wr_data [$];
  int          we_base, re_base, tx_base;

  function automatic logic [6:0] wrap_add(input logic [6:0] a, input int i);
    return 7'((int'(a) + i) % DEPTH);
  endfunction

  task automatic begin_txn();
    we_base = got_we.size();
    re_base = got_re.size();
    tx_base = got_tx.size();
    exp_we.delete();
    exp_re.delete();
    exp_tx.delete();
  endtask

  task automatic model_write(input logic [6:0] a);
    exp_tx.push_back(STATUS);
    foreach (wr_data[i]) begin
      exp_we.push_back({wrap_add(a, i), wr_data[i]});
      ref_mem[wrap_add(a, i)] = wr_data[i];
    end
  endtask

  task automatic model_read(input logic [6:0] a, input int n_dummy);
    exp_tx.push_back(STATUS);
    for (int i = 0; i <= n_dummy; i++) begin
      exp_re.push_back(wrap_add(a, i));
      exp_tx.push_back(ref_mem[wrap_add(a, i)]);
    end
  endtask

  task automatic end_txn(input string tag);
    check_eq({tag, "_we_cnt"}, 32'(got_we.size() - we_base), 32'(exp_we.size()));
    check_eq({tag, "_re_cnt"}, 32'(got_re.size() - re_base), 32'(exp_re.size()));
    check_eq({tag, "_tx_cnt"}, 32'(got_tx.size() - tx_base), 32'(exp_tx.size()));
    foreach (exp_we[i])
      if (we_base + i < got_we.size()) check_eq({tag, "_we"}, 32'(got_we[we_base + i]), 32'(exp_we[i]));
    foreach (exp_re[i])
      if (re_base + i < got_re.size()) check_eq({tag, "_re"}, 32'(got_re[re_base + i]), 32'(exp_re[i]));
    foreach (exp_tx[i])
      if (tx_base + i < got_tx.size()) check_eq({tag, "_tx"}, 32'(got_tx[tx_base + i]), 32'(exp_tx[i]));
    check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    check_eq({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
  endtask

  function automatic int rand_phase();
    int ph;
    ph = $urandom_range(1, 8);
    if (ph >= 5) ph++;
    return ph;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge sys_clk);
    #(rand_phase());
    byte_in  = b;
    byte_rdy = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #2 byte_rdy = 1'b0;
    repeat (6) @(posedge sys_clk);
  endtask

  task automatic cs_on();
    @(posedge sys_clk);
    #2 cs = 1'b1;
    repeat (5) @(posedge sys_clk);
  endtask

  task automatic cs_off();
    @(posedge sys_clk);
    #2 cs = 1'b0;
    repeat (6) @(posedge sys_clk);
  endtask

  task automatic do_write(input logic [6:0] a, input string tag);
    begin_txn();
    model_write(a);
    cs_on();
    send_byte({1'b0, a}, $urandom_range(4, 8));
    foreach (wr_data[i]) send_byte(wr_data[i], $urandom_range(4, 8));
    cs_off();
    end_txn(tag);
  endtask

  task automatic do_read(input logic [6:0] a, input int n_dummy, input string tag);
    begin_txn();
    model_read(a, n_dummy);
    cs_on();
    send_byte({1'b1, a}, $urandom_range(4, 8));
    for (int i = 0; i < n_dummy; i++) send_byte(8'($urandom), $urandom_range(4, 8));
    cs_off();
    end_txn(tag);
  endtask

  task automatic fill_wr(input int n);
    wr_data.delete();
    for (int i = 0; i < n; i++) wr_data.push_back(8'($urandom));
  endtask

  // Second byte lands while the fetch/load is still pending
  task automatic do_overrun(input logic [6:0] a, input logic with_clr, input string tag);
    begin_txn();
    model_read(a, 1);
    exp_ovr = 1'b1;
    cs_on();
    @(posedge sys_clk); #2 byte_in = {1'b1, a}; byte_rdy = 1'b1;
    @(posedge sys_clk); #2 byte_rdy = 1'b0;
    @(posedge sys_clk); #2 byte_rdy = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk); #2 clr_overrun = with_clr;
    @(posedge sys_clk); #2 clr_overrun = 1'b0;
    @(negedge sys_clk);
    check_eq({tag, "_set"}, 32'(overrun), 32'(1));
    repeat (3) @(posedge sys_clk);
    #2 byte_rdy = 1'b0;
    repeat (6) @(posedge sys_clk);
    send_byte(8'($urandom), 5);
    cs_off();
    end_txn(tag);
  endtask

  task automatic random_txns(input int n);
    for (int k = 0; k < n; k++) begin
      logic [6:0] a;
      a = 7'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        fill_wr($urandom_range(1, 6));
        do_write(a, "rnd_wr");
      end else begin
        do_read(a, $urandom_range(0, 5), "rnd_rd");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    int         lat;
    logic       seen;

    rst = 1'b1; cs = 1'b0; byte_rdy = 1'b0; byte_in = 8'h00; clr_overrun = 1'b0;
    bank_init = 1'b1;
    exp_ovr = 1'b0;
    for (int i = 0; i < DEPTH; i++) init_vals[i] = 8'($urandom);
    init_vals[7'h7E] = 8'h9C;
    init_vals[7'h7F] = 8'h4D;
    init_vals[7'h00] = 8'h01;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_vals[i];
    repeat (3) @(posedge sys_clk);
    #2 rst = 1'b0; bank_init = 1'b0;
    @(negedge sys_clk);
    check_eq("rst_busy",    32'(busy),      32'(0));
    check_eq("rst_tx_load", 32'(tx_load),   32'(0));
    check_eq("rst_we",      32'(reg_we),    32'(0));
    check_eq("rst_re",      32'(reg_re),    32'(0));
    check_eq("rst_ovr",     32'(overrun),   32'(0));
    check_eq("rst_tx_byte", 32'(tx_byte),   32'(0));
    check_eq("rst_addr",    32'(reg_addr),  32'(0));
    check_eq("rst_wdata",   32'(reg_wdata), 32'(0));

    // Directed write burst and wrapping read burst
    wr_data.delete();
    wr_data.push_back(8'h11); wr_data.push_back(8'h22); wr_data.push_back(8'h33);
    do_write(7'h05, "wr_burst");
    do_read(7'h7E, 2, "rd_wrap");

    // Synchroniser latency and single strobe on a long byte_rdy level
    a = 7'($urandom);
    d = 8'($urandom);
    wr_data.delete(); wr_data.push_back(d);
    begin_txn();
    model_write(a);
    cs_on();
    send_byte({1'b0, a}, 5);
    @(posedge sys_clk);
    #(rand_phase());
    byte_in = d; byte_rdy = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
      seen = reg_we;
    end
    check_eq("sync_latency", 32'(seen && (lat <= SYNC_STAGES + 1)), 32'(1));
    repeat (20 - lat) @(posedge sys_clk);
    #2 byte_rdy = 1'b0;
    repeat (6) @(posedge sys_clk);
    cs_off();
    end_txn("sync_hold");

    // Abort: cs drops just before a data byte would be taken
    a = 7'($urandom);
    fill_wr(1);
    begin_txn();
    model_write(a);
    cs_on();
    send_byte({1'b0, a}, 5);
    send_byte(wr_data[0], 5);
    @(posedge sys_clk); #2 cs = 1'b0;
    @(posedge sys_clk); #2 byte_in = 8'($urandom); byte_rdy = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_eq("abort_busy", 32'(busy), 32'(0));
    repeat (4) @(posedge sys_clk);
    #2 byte_rdy = 1'b0;
    repeat (6) @(posedge sys_clk);
    end_txn("abort");
    fill_wr(1);
    do_write(7'h10, "after_abort");

    random_txns(6);

    // Overrun: sticky across transfers, clearable, set beats clear
    do_overrun(7'($urandom), 1'b0, "ovr");
    fill_wr(2);
    do_write(7'($urandom), "ovr_sticky");
    @(posedge sys_clk); #2 clr_overrun = 1'b1;
    @(posedge sys_clk); #2 clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    @(negedge sys_clk);
    check_eq("ovr_clear", 32'(overrun), 32'(0));
    do_overrun(7'($urandom), 1'b1, "ovr_vs_clr");

    // Reset in the middle of a write burst
    a = 7'($urandom);
    fill_wr(1);
    begin_txn();
    model_write(a);
    cs_on();
    send_byte({1'b0, a}, 5);
    send_byte(wr_data[0], 5);
    @(posedge sys_clk); #2 byte_in = 8'($urandom); byte_rdy = 1'b1;
    @(posedge sys_clk); #2 rst = 1'b1;
    @(posedge sys_clk); #2 cs = 1'b0; byte_rdy = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk); #2 rst = 1'b0;
    exp_ovr = 1'b0;
    @(negedge sys_clk);
    check_eq("mid_rst_busy",    32'(busy),    32'(0));
    check_eq("mid_rst_tx_load", 32'(tx_load), 32'(0));
    check_eq("mid_rst_we",      32'(reg_we),  32'(0));
    check_eq("mid_rst_ovr",     32'(overrun), 32'(0));
    check_eq("mid_rst_tx_byte", 32'(tx_byte), 32'(0));
    repeat (6) @(posedge sys_clk);
    end_txn("mid_rst");

    random_txns(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
